// File: rtl/lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator
//   Load/store unit between the MEM pipeline stage and a word-wide data
//   memory. Takes one request at a time, drives word-aligned accesses with
//   byte enables, and splits an access that straddles a word boundary into
//   two word accesses. Load data is merged, lane-aligned and sign/zero
//   extended into a single-cycle response.
//
// Parameters
//   ALLOW_MISALIGNED : 1 = split misaligned accesses, 0 = report them as errors
//   ADDR_W           : byte address width
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_we, req_funct3            store flag, RV32I size/sign code
//   req_addr, req_wdata           byte address, LSB-justified store data
//   resp_valid/resp_rdata/err     one-cycle completion pulse with result
//   mem_req/we/addr/be/wdata      memory strobe, write flag, word address,
//                                 byte lanes, lane-positioned write data
//   mem_rdata                     read data, one cycle after a read strobe
// ---------------------------------------------------------------------------
module lsu_mem_initiator #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_CAP0, S_ACC1, S_CAP1, S_DONE
  } state_e;

  // Everything about the accepted request that later states need.
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] word0;
    logic [1:0]        off;
    logic [7:0]        mask;      // byte lanes over two consecutive words
    logic              split;
    logic              err;
    logic [31:0]       wdata_rot; // store data already in its byte lanes
  } req_t;

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] off);
    logic [63:0] t;
    t = {w, w} << {off, 3'b000};
    return t[63:32];
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] off);
    logic [63:0] t;
    t = {hi, lo} >> {off, 3'b000};
    return t[31:0];
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // ---------------- request decode ----------------
  req_t       dec;
  logic [3:0] dec_base;
  logic       dec_illegal;
  logic       dec_misal;

  // NOTE: every variable written in an always_comb gets a value before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    dec_base = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   dec_base = 4'b0001;
      2'b01:   dec_base = 4'b0011;
      2'b10:   dec_base = 4'b1111;
      default: dec_base = 4'b0000;
    endcase
    dec_illegal = req_we ? (req_funct3 > 3'b010)
                         : (req_funct3 inside {3'b011, 3'b110, 3'b111});
    dec_misal   = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    dec.we        = req_we;
    dec.funct3    = req_funct3;
    dec.word0     = {req_addr[ADDR_W-1:2], 2'b00};
    dec.off       = req_addr[1:0];
    dec.mask      = {4'b0000, dec_base} << req_addr[1:0];
    dec.split     = |dec.mask[7:4];
    dec.err       = dec_illegal || (dec_misal && !ALLOW_MISALIGNED);
    dec.wdata_rot = rotl_bytes(req_wdata, req_addr[1:0]);
  end

  // ---------------- state and registered outputs ----------------
  state_e            state_q, state_d;
  req_t              cur_q, cur_d;
  logic [31:0]       rd0_q, rd0_d, rd1_q, rd1_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;

    case (state_q)
      S_IDLE: if (req_valid) begin
        cur_d   = dec;
        rd0_d   = 32'h0;
        rd1_d   = 32'h0;   // unsplit loads merge against a zero upper word
        state_d = dec.err ? S_DONE : S_ACC0;
      end
      S_ACC0:  state_d = cur_q.we ? (cur_q.split ? S_ACC1 : S_DONE) : S_CAP0;
      S_CAP0: begin
        rd0_d   = mem_rdata;
        state_d = cur_q.split ? S_ACC1 : S_DONE;
      end
      S_ACC1:  state_d = cur_q.we ? S_DONE : S_CAP1;
      S_CAP1: begin
        rd1_d   = mem_rdata;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state and
    // next capture values; read data captured this cycle feeds the result.
    req_ready_d  = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_ACC0) || (state_d == S_ACC1);
    mem_we_d     = mem_req_d && cur_d.we;
    mem_wdata_d  = mem_req_d ? cur_d.wdata_rot : 32'h0;
    mem_addr_d   = '0;
    mem_be_d     = 4'b0000;
    if (state_d == S_ACC0) begin
      mem_addr_d = cur_d.word0;
      mem_be_d   = cur_d.mask[3:0];
    end else if (state_d == S_ACC1) begin
      mem_addr_d = cur_d.word0 + ADDR_W'(4);   // wraps at the top of memory
      mem_be_d   = cur_d.mask[7:4];
    end
    resp_valid_d = (state_d == S_DONE);
    resp_err_d   = resp_valid_d && cur_d.err;
    resp_rdata_d = (resp_valid_d && !cur_d.we && !cur_d.err)
                 ? extend(cur_d.funct3, extract(rd1_d, rd0_d, cur_d.off))
                 : 32'h0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      rd0_q        <= 32'h0;
      rd1_q        <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
